// File: rtl/itr_ctrl.sv
// itr_ctrl: row-issue sequencer for the in-place radix-8 FFT.
// It runs one LOAD pass (rows taken from IOBUF) and then NSTAGE CALC passes
// (rows taken from FSC). Each pass is followed by a fixed write-back gap.
module itr_ctrl #(
  parameter int N_LOG2    = 9,
  parameter int NSTAGE    = 3,
  parameter int DRAIN_CYC = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic              HOLD,
  output logic              SEL_ITR,
  output logic [2:0]        SEL_PERMR,
  output logic [N_LOG2-4:0] RADDR,
  output logic [1:0]        STAGE,
  output logic              RVALID,
  output logic              BUSY,
  output logic              DONE
);
  localparam int AW = N_LOG2 - 3;
  localparam int ND = (AW + 2) / 3;   // number of octal digits in a row address
  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [AW-1:0] RLAST = '1;
  localparam logic [CW-1:0] DLAST = CW'(DRAIN_CYC - 1);
  localparam logic [1:0]    SLAST = 2'(NSTAGE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, CALC, FIN} state_t;

  state_t        state;
  logic [AW-1:0] r;
  logic [AW-1:0] r_inc;
  logic [CW-1:0] dcnt;
  logic          act;    // a row is presented on RADDR this cycle (LOAD/CALC)

  // Rotation = sum of the octal digits of the row, mod 8.
  // The top digit is zero-padded when AW is not a multiple of 3.
  function automatic logic [2:0] dsum(input logic [AW-1:0] v);
    logic [3*ND-1:0] p;
    logic [2:0]      s;
    p        = '0;
    p[AW-1:0] = v;
    s        = '0;
    for (int i = 0; i < ND; i++) s = s + p[3*i +: 3];
    return s;
  endfunction

  assign r_inc = r + AW'(1);

  // HOLD stalls issue in the cycle it is raised. The presented row stays
  // registered, and only the valid qualifier sees HOLD directly.
  assign RVALID = act & ~HOLD;

  // Sequencer: state, row/drain counters and all registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      r         <= '0;
      dcnt      <= '0;
      act       <= 1'b0;
      STAGE     <= '0;
      SEL_ITR   <= 1'b0;
      SEL_PERMR <= '0;
      RADDR     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          state     <= LOAD;
          r         <= '0;
          STAGE     <= '0;
          SEL_ITR   <= 1'b0;
          RADDR     <= '0;
          SEL_PERMR <= '0;
          act       <= 1'b1;
          BUSY      <= 1'b1;
        end
        LOAD, CALC: if (!HOLD) begin
          if (r == RLAST) begin
            // RADDR/SEL_PERMR keep the last row through the gap.
            state <= DRAIN;
            r     <= '0;
            dcnt  <= '0;
            act   <= 1'b0;
          end else begin
            r         <= r_inc;
            RADDR     <= r_inc;
            SEL_PERMR <= dsum(r_inc);
          end
        end
        DRAIN: if (dcnt == DLAST) begin
          // SEL_ITR is still 0 only when the gap follows the LOAD pass.
          if (!SEL_ITR || STAGE != SLAST) begin
            state     <= CALC;
            act       <= 1'b1;
            SEL_ITR   <= 1'b1;
            RADDR     <= '0;
            SEL_PERMR <= '0;
            if (SEL_ITR) STAGE <= STAGE + 2'd1;
          end else begin
            state <= FIN;
            DONE  <= 1'b1;
          end
        end else begin
          dcnt <= dcnt + CW'(1);
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
